// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter - round-robin, packet-locking arbiter in front of uart_tx
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter int BUSY_WAIT   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic               i_tx_busy,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic [1:0]         o_grant_id,
  output logic               o_lock_active,
  output logic               o_timeout_err
);

  localparam int          c_WW        = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(BUSY_WAIT - 1);
  localparam logic [15:0] c_TO_LAST   = 16'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  c_PTR_INIT  = 2'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_rr_ptr;
  logic [15:0]     r_to_cnt;
  logic [c_WW-1:0] r_wait_cnt;
  logic [7:0]      r_tx_data;
  logic [1:0]      r_grant_id;
  logic            r_lock;
  logic            r_timeout;

  logic            w_found;
  logic [1:0]      w_cand;
  logic            w_owner_valid;
  logic [7:0]      w_cand_data;
  logic            w_cand_last;
  logic            w_accept;
  logic            w_to_count;
  logic            w_to_fire;

  // Candidate selection: the lock owner only, or a rotating search after r_rr_ptr.
  always_comb begin
    w_found       = 1'b0;
    w_cand        = 2'd0;
    w_owner_valid = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (2'(j) == r_grant_id) w_owner_valid = i_req_valid[j];
    end
    if (r_lock) begin
      w_found = w_owner_valid;
      w_cand  = r_grant_id;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        for (int j = 0; j < N_REQ; j++) begin
          if (!w_found && i_req_valid[j] && (j == (int'(r_rr_ptr) + k) % N_REQ)) begin
            w_found = 1'b1;
            w_cand  = 2'(j);
          end
        end
      end
    end
  end

  assign w_accept   = i_rst_n && (r_state == S_IDLE) && w_found && !i_tx_busy;
  assign w_to_count = (r_state == S_IDLE) && r_lock && !w_owner_valid;
  assign w_to_fire  = w_to_count && (r_to_cnt == c_TO_LAST);

  always_comb begin
    o_req_ready = '0;
    w_cand_data = 8'h00;
    w_cand_last = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (2'(j) == w_cand) begin
        o_req_ready[j] = w_accept;
        w_cand_data    = i_req_data[8*j +: 8];
        w_cand_last    = i_req_last[j];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_tx_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        o_tx_start  = 1'b1;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // Give up on a busy flag that never rises after BUSY_WAIT cycles.
        if (i_tx_busy)                      w_state_nxt = S_WAIT_LO;
        else if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = S_IDLE;
      end
      S_WAIT_LO: begin
        if (!i_tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= c_PTR_INIT;
      r_to_cnt   <= '0;
      r_wait_cnt <= '0;
      r_tx_data  <= 8'h00;
      r_grant_id <= 2'd0;
      r_lock     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A stalled lock owner leaves r_rr_ptr on itself so the search restarts after it.
      if (w_accept) begin
        r_tx_data  <= w_cand_data;
        r_grant_id <= w_cand;
        r_rr_ptr   <= w_cand;
        r_lock     <= ~w_cand_last;
        r_to_cnt   <= '0;
      end else if (w_to_fire) begin
        r_lock    <= 1'b0;
        r_timeout <= 1'b1;
        r_to_cnt  <= '0;
      end else if (!r_lock) begin
        r_to_cnt <= '0;
      end else if (w_to_count) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end

      if (r_state == S_START)                      r_wait_cnt <= '0;
      else if (r_state == S_WAIT_HI && !i_tx_busy) r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_grant_id    = r_grant_id;
  assign o_lock_active = r_lock;
  assign o_timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter - self-checking bench for uart_tx_arbiter
// Revision 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int c_N  = 3;
  localparam int c_TO = 16;
  localparam int c_BW = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        lock_active;
  logic        timeout_err;

  int total;
  int bad;
  int busy_len;
  int busy_rem;
  bit busy_pend;

  uart_tx_arbiter #(.N_REQ(c_N), .TIMEOUT_CYC(c_TO), .BUSY_WAIT(c_BW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(req_ready), .i_tx_busy(busy),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_grant_id(grant_id),
    .o_lock_active(lock_active), .o_timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: busy rises the cycle after tx_start and stays high busy_len cycles.
  initial begin
    busy = 1'b0; busy_rem = 0; busy_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_pend) begin busy_rem = busy_len; busy_pend = 1'b0; end
      if (busy_rem > 0) begin busy = 1'b1; busy_rem--; end
      else busy = 1'b0;
      if (tx_start) busy_pend = 1'b1;
    end
  end

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [23:0] data;
    int          exp_id;
    logic        exp_lock;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_ready(input string name, output logic [2:0] got);
    int n;
    n = 0;
    #1;
    while (req_ready == 3'b000 && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    got = req_ready;
    if (got == 3'b000) begin
      total++; bad++;
      $display("FAIL %s: no req_ready within %0d cycles", name, n);
    end
  endtask

  task automatic do_reset();
    int n;
    tick(); rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    tick(); tick();
    n = 0;
    while ((busy || busy_pend) && n < 100) begin tick(); n++; end
    tick(); rst_n = 1'b1;
  endtask

  function automatic int rr_pick(input logic [2:0] v, input int ptr, input int lk);
    if (lk >= 0) return v[lk] ? lk : -1;
    for (int k = 1; k <= 3; k++) begin
      int j;
      j = (ptr + k) % 3;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    logic [2:0] got;
    int         k;
    logic       any_rdy;
    logic       any_to;
    int         m_ptr, m_lock, stall, id, exp_id;
    bit         pend_acc, done, abort, spurious, seen_to;
    logic [7:0] exp_d;
    logic       exp_l;
    logic [2:0] last_rdy;
    bit         pres [3];
    int         rem  [3];
    int         dly  [3];
    int         npk  [3];
    logic [7:0] pd   [3];
    logic       pl   [3];

    total = 0; bad = 0; busy_len = 3;
    rst_n = 1'b0; req_valid = 3'b111; req_last = 3'b101; req_data = 24'hA5C3E1;

    vt[0] = '{valid: 3'b111, last: 3'b111, data: 24'h332211, exp_id: 0, exp_lock: 1'b0};
    vt[1] = '{valid: 3'b111, last: 3'b111, data: 24'h332211, exp_id: 1, exp_lock: 1'b0};
    vt[2] = '{valid: 3'b111, last: 3'b111, data: 24'h332211, exp_id: 2, exp_lock: 1'b0};
    vt[3] = '{valid: 3'b111, last: 3'b111, data: 24'h332211, exp_id: 0, exp_lock: 1'b0};
    vt[4] = '{valid: 3'b111, last: 3'b111, data: 24'h332211, exp_id: 1, exp_lock: 1'b0};
    vt[5] = '{valid: 3'b111, last: 3'b111, data: 24'h332211, exp_id: 2, exp_lock: 1'b0};
    vt[6] = '{valid: 3'b010, last: 3'b000, data: 24'h001000, exp_id: 1, exp_lock: 1'b1};
    vt[7] = '{valid: 3'b011, last: 3'b001, data: 24'h001140, exp_id: 1, exp_lock: 1'b1};
    vt[8] = '{valid: 3'b011, last: 3'b011, data: 24'h001240, exp_id: 1, exp_lock: 1'b0};
    vt[9] = '{valid: 3'b011, last: 3'b011, data: 24'h001340, exp_id: 0, exp_lock: 1'b0};

    // Reset state with requesters valid
    tick(); tick(); settle();
    check("rst_ready", req_ready, 3'b000);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant", grant_id, 2'd0);
    check("rst_lock", lock_active, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);

    // Single byte with a 10-cycle busy window
    busy_len = 10;
    do_reset();
    tick(); req_valid = 3'b001; req_data = 24'h000041; req_last = 3'b001; settle();
    check("sb_ready_t0", req_ready, 3'b001);
    tick(); req_data = 24'h000042; settle();
    check("sb_tx_start", tx_start, 1'b1);
    check("sb_tx_data", tx_data, 8'h41);
    check("sb_grant", grant_id, 2'd0);
    check("sb_lock", lock_active, 1'b0);
    k = 1; got = '0;
    while (got == 3'b000 && k < 40) begin tick(); k++; settle(); got = req_ready; end
    check("sb_gap_ge12", (k >= 12), 1'b1);
    check("sb_second_ready", got, 3'b001);
    tick(); req_valid = '0; settle();
    check("sb_second_data", tx_data, 8'h42);

    // Round-robin and packet lock vectors
    busy_len = 3;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [2:0] g;
      logic [7:0] ed;
      tick();
      req_valid = vt[i].valid; req_last = vt[i].last; req_data = vt[i].data;
      wait_ready($sformatf("tbl%0d_wait", i), g);
      ed = vt[i].data[8*vt[i].exp_id +: 8];
      check($sformatf("tbl%0d_ready", i), g, 3'b001 << vt[i].exp_id);
      tick(); req_valid = '0; settle();
      check($sformatf("tbl%0d_start", i), tx_start, 1'b1);
      check($sformatf("tbl%0d_data", i), tx_data, ed);
      check($sformatf("tbl%0d_grant", i), grant_id, vt[i].exp_id);
      check($sformatf("tbl%0d_lock", i), lock_active, vt[i].exp_lock);
    end

    // Busy stuck low: second accept exactly BUSY_WAIT cycles after WAIT_HI entry
    busy_len = 0;
    do_reset();
    tick(); req_valid = 3'b001; req_data = 24'h000061; req_last = 3'b001; settle();
    check("stuck_first_ready", req_ready, 3'b001);
    tick(); req_data = 24'h000062; settle();
    check("stuck_first_start", tx_start, 1'b1);
    any_rdy = 1'b0;
    for (int c = 2; c <= 5; c++) begin tick(); settle(); any_rdy |= (req_ready != 3'b000); end
    check("stuck_early_ready", any_rdy, 1'b0);
    tick(); settle();
    check("stuck_second_ready", req_ready, 3'b001);
    tick(); req_valid = '0; settle();
    check("stuck_second_start", tx_start, 1'b1);
    check("stuck_second_data", tx_data, 8'h62);

    // Watchdog: req2 stalls mid-packet, req0 waits
    do_reset();
    tick(); req_valid = 3'b100; req_data = 24'h550000; req_last = 3'b000; settle();
    check("to_first_ready", req_ready, 3'b100);
    tick(); req_valid = 3'b001; req_data = 24'h000077; req_last = 3'b001; settle();
    check("to_lock_set", lock_active, 1'b1);
    any_rdy = 1'b0; any_to = 1'b0;
    for (int c = 2; c <= 21; c++) begin
      tick(); settle();
      any_rdy |= (req_ready != 3'b000);
      any_to  |= timeout_err;
    end
    check("to_no_ready_while_locked", any_rdy, 1'b0);
    check("to_no_early_timeout", any_to, 1'b0);
    check("to_lock_before", lock_active, 1'b1);
    tick(); settle();
    check("to_timeout_pulse", timeout_err, 1'b1);
    check("to_lock_cleared", lock_active, 1'b0);
    check("to_next_grant_req0", req_ready, 3'b001);
    tick(); req_valid = '0; settle();
    check("to_pulse_single", timeout_err, 1'b0);
    check("to_req0_data", tx_data, 8'h77);

    // Lock owner returns on the cycle the watchdog would fire: accept wins
    tick(); req_valid = 3'b010; req_data = 24'h006600; req_last = 3'b000;
    wait_ready("aw_wait", got);
    check("aw_first_ready", got, 3'b010);
    any_to = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick(); req_valid = '0; settle();
      any_to |= timeout_err;
    end
    tick(); req_valid = 3'b010; req_data = 24'h006700; req_last = 3'b010; settle();
    check("aw_ready_at_fire", req_ready, 3'b010);
    tick(); req_valid = '0; settle();
    any_to |= timeout_err;
    check("aw_no_timeout", any_to, 1'b0);
    check("aw_data", tx_data, 8'h67);
    check("aw_lock_closed", lock_active, 1'b0);

    // Reset during WAIT_LO with lock held
    busy_len = 10;
    do_reset();
    tick(); req_valid = 3'b010; req_data = 24'h00A000; req_last = 3'b000; settle();
    check("rm_first_ready", req_ready, 3'b010);
    tick(); req_valid = 3'b011; req_data = 24'h00A15A; req_last = 3'b001; settle();
    tick(); tick(); tick(); settle();
    check("rm_lock_held", lock_active, 1'b1);
    tick(); rst_n = 1'b0; settle();
    check("rm_ready_in_reset", req_ready, 3'b000);
    tick(); settle();
    check("rm_tx_start", tx_start, 1'b0);
    check("rm_tx_data", tx_data, 8'h00);
    check("rm_grant", grant_id, 2'd0);
    check("rm_lock", lock_active, 1'b0);
    check("rm_timeout", timeout_err, 1'b0);
    k = 0;
    while ((busy || busy_pend) && k < 40) begin tick(); k++; end
    tick(); rst_n = 1'b1;
    wait_ready("rm_wait", got);
    check("rm_req0_priority", got, 3'b001);
    tick(); req_valid = '0; settle();
    check("rm_req0_data", tx_data, 8'h5A);

    // Randomized traffic against a transaction-level model
    do_reset();
    m_ptr = 2; m_lock = -1; stall = 0; exp_id = 0; exp_d = '0; exp_l = 1'b0;
    pend_acc = 0; done = 0; abort = 0; spurious = 0; seen_to = 0; last_rdy = '0;
    for (int i = 0; i < 3; i++) begin
      pres[i] = 0; rem[i] = 0; dly[i] = 0; npk[i] = 0; pd[i] = '0; pl[i] = 1'b0;
    end
    for (int cy = 0; cy < 6000 && !done && !abort; cy++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (last_rdy[i]) begin
          pres[i] = 0; rem[i]--;
          if (rem[i] == 0) npk[i]++;
          dly[i] = $urandom_range(0, 3);
        end
        if (!pres[i]) begin
          if (dly[i] > 0) dly[i]--;
          else if (rem[i] > 0 || npk[i] < 12) begin
            if (rem[i] == 0) rem[i] = $urandom_range(1, 3);
            pres[i] = 1; pd[i] = 8'($urandom); pl[i] = (rem[i] == 1);
          end
        end
        req_valid[i] = pres[i]; req_data[8*i +: 8] = pd[i]; req_last[i] = pl[i];
      end
      settle();
      if (timeout_err) seen_to = 1;
      if (pend_acc) begin
        check("rnd_start", tx_start, 1'b1);
        check("rnd_data", tx_data, exp_d);
        check("rnd_grant", grant_id, exp_id);
        check("rnd_lock", lock_active, !exp_l);
      end else if (tx_start) spurious = 1;
      pend_acc = 0;
      last_rdy = req_ready;
      if (req_ready != 3'b000) begin
        id = req_ready[0] ? 0 : (req_ready[1] ? 1 : 2);
        check("rnd_onehot", $onehot(req_ready), 1'b1);
        check("rnd_busy_low", busy, 1'b0);
        check("rnd_pick", id, rr_pick(req_valid, m_ptr, m_lock));
        exp_id = id; exp_d = pd[id]; exp_l = pl[id]; pend_acc = 1;
        m_ptr = id; m_lock = pl[id] ? -1 : id;
        busy_len = $urandom_range(0, 6);
        stall = 0;
      end else if (!busy && rr_pick(req_valid, m_ptr, m_lock) >= 0) begin
        stall++;
        if (stall > 6) begin
          check("rnd_stall_cycles", stall, 6);
          abort = 1;
        end
      end
      done = !pend_acc;
      for (int i = 0; i < 3; i++) if (pres[i] || npk[i] < 12) done = 0;
    end
    check("rnd_complete", done, 1'b1);
    check("rnd_no_timeout", seen_to, 1'b0);
    check("rnd_no_spurious_start", spurious, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
